// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared widths, control-bit indices and bubble constant for MIPS pipeline registers
package mips_pipe_pkg;

  localparam int DEF_CTRL_W = 10;
  localparam int DEF_DATA_W = 32;

  // Bit positions inside the control field carried between stages.
  localparam int CTRL_REG_DST   = 0;
  localparam int CTRL_ALU_SRC   = 1;
  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_REG_WRITE = 5;
  localparam int CTRL_BRANCH    = 6;
  localparam int CTRL_JUMP      = 7;
  localparam int CTRL_ALU_OP_LO = 8;
  localparam int CTRL_ALU_OP_HI = 9;

  typedef logic [DEF_CTRL_W-1:0] ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid + ctrl + data storage slot with load/clear
module pipe_entry #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Load wins over clear so a slot can be refilled in the cycle it drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline-stage register with optional skid buffer, freeze and flush
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              pass;
  logic              in_fire;
  logic              out_fire;
  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  assign pass      = hit && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = pass && head_valid;
  assign out_ctrl  = out_valid ? head_ctrl : CTRL_W'(NOP_CTRL);
  assign out_data  = head_data;

  if (SKID == 0) begin : g_single
    assign in_ready  = rst_n && pass && (!head_valid || out_ready);
    assign occupancy = {1'b0, head_valid};

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_e0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (in_fire),
      .clear     (flush || out_fire),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (head_valid),
      .ctrl      (head_ctrl),
      .data      (head_data)
    );
  end else begin : g_skid
    logic              ready_q;
    logic              v1;
    logic [CTRL_W-1:0] c1;
    logic [DATA_W-1:0] d1;
    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic              e0_load;
    logic              e0_clear;
    logic              e1_load;
    logic              e1_clear;

    assign occ      = {1'b0, head_valid} + {1'b0, v1};
    assign occ_next = flush ? 2'd0 : occ + {1'b0, in_fire} - {1'b0, out_fire};
    assign in_ready = rst_n && pass && ready_q;

    // Head refills from the tail slot when both are held, else from the input.
    assign e0_load  = (out_fire && v1) || (in_fire && (!head_valid || out_fire));
    assign e0_clear = flush || out_fire;
    assign e1_load  = in_fire && head_valid && !out_fire;
    assign e1_clear = flush || out_fire;

    always_ff @(posedge clk) begin
      if (!rst_n) ready_q <= 1'b1;
      else        ready_q <= (occ_next != 2'd2);
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_e0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (e0_load),
      .clear     (e0_clear),
      .load_ctrl (v1 ? c1 : in_ctrl),
      .load_data (v1 ? d1 : in_data),
      .valid     (head_valid),
      .ctrl      (head_ctrl),
      .data      (head_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_e1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (e1_load),
      .clear     (e1_clear),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (v1),
      .ctrl      (c1),
      .data      (d1)
    );

    assign occupancy = occ;
  end

endmodule
